// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware channel FIFO between the router register
// block and one destination port. Each entry stores {sop, data}. The FIFO
// tracks the remaining bytes of the packet being drained (pkt_busy), and
// it latches misuse (write while full, or read while empty) in err.
// Optional build macro ROUTER_FIFO_TRISTATE_EN: legacy tri-stated dout
// while the channel is idle.
module router_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LEN_MSB    = 7,
  parameter int LEN_LSB    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         soft_rst,
  input  logic                         we,
  input  logic                         re,
  input  logic                         lfd_state,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         pkt_busy,
  output logic                         err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PW     = LEN_MSB - LEN_LSB + 2;

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_W:0]       wptr;
  logic [ADDR_W:0]       rptr;
  logic [PW-1:0]         pkt_cnt;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  flush;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH:0]   rd_entry;
  logic [PW-2:0]         hdr_len;

  assign flush    = !rst || soft_rst;
  assign empty    = (wptr == rptr);
  assign full     = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
                    (wptr[ADDR_W] != rptr[ADDR_W]);
  assign count    = wptr - rptr;
  assign wr_ok    = we && !full && !flush;
  assign rd_ok    = re && !empty && !flush;
  assign rd_entry = mem[rptr[ADDR_W-1:0]];
  assign hdr_len  = rd_entry[LEN_MSB:LEN_LSB];
  assign pkt_busy = (pkt_cnt != '0);

  // Storage array; contents are not reset, validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wptr[ADDR_W-1:0]] <= {lfd_state, din};
  end

  // Write pointer.
  always_ff @(posedge clk) begin
    if (flush)
      wptr <= '0;
    else if (wr_ok)
      wptr <= wptr + (ADDR_W+1)'(1);
  end

  // Read pointer and the valid strobe for each newly read byte.
  always_ff @(posedge clk) begin
    if (flush) begin
      rptr       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_ok;
      if (rd_ok)
        rptr <= rptr + (ADDR_W+1)'(1);
    end
  end

  // Read data register: cleared by either reset, otherwise holds between reads.
  always_ff @(posedge clk) begin
    if (flush)
      dout_q <= '0;
    else if (rd_ok)
      dout_q <= rd_entry[DATA_WIDTH-1:0];
  end

  // Remaining bytes of the draining packet: headers (re)load length+parity.
  always_ff @(posedge clk) begin
    if (flush)
      pkt_cnt <= '0;
    else if (rd_ok) begin
      if (rd_entry[DATA_WIDTH])
        pkt_cnt <= {1'b0, hdr_len} + PW'(1);
      else if (pkt_cnt != '0)
        pkt_cnt <= pkt_cnt - PW'(1);
    end
  end

  // Sticky misuse flag, evaluated on pre-edge full/empty.
  always_ff @(posedge clk) begin
    if (flush)
      err <= 1'b0;
    else if ((we && full) || (re && empty))
      err <= 1'b1;
  end

`ifdef ROUTER_FIFO_TRISTATE_EN
  logic dout_oe;

  // Output enable: off after soft_rst and on idle cycles outside a packet.
  always_ff @(posedge clk) begin
    if (!rst)
      dout_oe <= 1'b1;
    else if (soft_rst)
      dout_oe <= 1'b0;
    else if (rd_ok)
      dout_oe <= 1'b1;
    else if (pkt_cnt == '0)
      dout_oe <= 1'b0;
  end

  assign dout = dout_oe ? dout_q : 'z;
`else
  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed self-checking bench for router_pkt_fifo (DEPTH=16, 8-bit data).
module tb_router_pkt_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_rst = 1'b0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       pkt_busy;
  logic       err;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [7:0] idle_dout;

  router_pkt_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(16),
    .LEN_MSB(7),
    .LEN_LSB(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .soft_rst(soft_rst),
    .we(we),
    .re(re),
    .lfd_state(lfd_state),
    .din(din),
    .dout(dout),
    .dout_valid(dout_valid),
    .empty(empty),
    .full(full),
    .count(count),
    .pkt_busy(pkt_busy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_channel();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b1;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pkt_busy", 32'(pkt_busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Read on empty FIFO
`ifdef ROUTER_FIFO_TRISTATE_EN
    idle_dout = 'z;
`else
    idle_dout = 8'h00;
`endif
    re = 1'b1;
    tick();
    re = 1'b0;
    check("empty_rd_valid", 32'(dout_valid), 32'd0);
    check("empty_rd_dout", 32'(dout), 32'(idle_dout));
    check("empty_rd_err", 32'(err), 32'd1);
    check("empty_rd_count", 32'(count), 32'd0);
    flush_channel();
    check("soft_rst_clears_err", 32'(err), 32'd0);

    // Fill to full, then overflow
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 8'(i + 1);
      tick();
      if (i == 14) check("count_15", 32'(count), 32'd15);
      if (i == 14) check("not_full_15", 32'(full), 32'd0);
    end
    check("fill_count", 32'(count), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_err", 32'(err), 32'd0);
    din = 8'h55;
    tick();
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_full", 32'(full), 32'd1);
    // Write while full is rejected even with a same-cycle read
    re  = 1'b1;
    din = 8'h66;
    tick();
    check("full_rw_dout", 32'(dout), 32'h01);
    check("full_rw_valid", 32'(dout_valid), 32'd1);
    check("full_rw_count", 32'(count), 32'd15);
    we = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      tick();
      check("drain_dout", 32'(dout), 32'(i));
    end
    re = 1'b0;
    tick();
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_valid", 32'(dout_valid), 32'd0);
`ifdef ROUTER_FIFO_TRISTATE_EN
    check("drain_hold", 32'(dout), 32'(8'bz));
`else
    check("drain_hold", 32'(dout), 32'h10);
`endif
    check("drain_pkt_busy", 32'(pkt_busy), 32'd0);
    flush_channel();

    // One packet: header 0x0C (length 3), 3 payload, parity
    we = 1'b1;
    lfd_state = 1'b1;
    din = 8'h0C;
    tick();
    lfd_state = 1'b0;
    din = 8'hA1; tick();
    din = 8'hA2; tick();
    din = 8'hA3; tick();
    din = 8'h5B; tick();
    we = 1'b0;
    check("pkt_count", 32'(count), 32'd5);
    check("pkt_busy_pre", 32'(pkt_busy), 32'd0);
    re = 1'b1;
    tick();
    check("pkt_hdr", 32'(dout), 32'h0C);
    check("pkt_busy_hdr", 32'(pkt_busy), 32'd1);
    tick();
    check("pkt_p1", 32'(dout), 32'hA1);
    check("pkt_busy_p1", 32'(pkt_busy), 32'd1);
    tick();
    check("pkt_p2", 32'(dout), 32'hA2);
    check("pkt_busy_p2", 32'(pkt_busy), 32'd1);
    tick();
    check("pkt_p3", 32'(dout), 32'hA3);
    check("pkt_busy_p3", 32'(pkt_busy), 32'd1);
    tick();
    check("pkt_par", 32'(dout), 32'h5B);
    check("pkt_busy_par", 32'(pkt_busy), 32'd0);
    check("pkt_empty", 32'(empty), 32'd1);
    re = 1'b0;
    tick();
    check("pkt_err", 32'(err), 32'd0);
    flush_channel();

    // Sustained simultaneous read/write with 8 entries held, across wraps
    we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(8'h30 + i);
      tick();
    end
    re = 1'b1;
    for (int k = 0; k < 40; k++) begin
      din = 8'(8'h38 + k);
      tick();
      check("stream_dout", 32'(dout), 32'(8'h30 + k));
      check("stream_count", 32'(count), 32'd8);
    end
    we = 1'b0;
    re = 1'b0;
    tick();
    check("stream_err", 32'(err), 32'd0);
    flush_channel();

    // soft_rst mid-packet with 5 entries stored; requests ignored that cycle
    we = 1'b1;
    lfd_state = 1'b1;
    din = 8'h14;
    tick();
    lfd_state = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      din = 8'(8'hB0 + i);
      tick();
    end
    we = 1'b0;
    re = 1'b1;
    tick();
    tick();
    re = 1'b0;
    check("mid_dout", 32'(dout), 32'hB1);
    check("mid_count", 32'(count), 32'd5);
    check("mid_busy", 32'(pkt_busy), 32'd1);
    we = 1'b1;
    re = 1'b1;
    din = 8'hEE;
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    we = 1'b0;
    re = 1'b0;
    check("srst_empty", 32'(empty), 32'd1);
    check("srst_count", 32'(count), 32'd0);
    check("srst_busy", 32'(pkt_busy), 32'd0);
    check("srst_err", 32'(err), 32'd0);
    check("srst_valid", 32'(dout_valid), 32'd0);
`ifdef ROUTER_FIFO_TRISTATE_EN
    check("srst_dout", 32'(dout), 32'(8'bz));
`else
    check("srst_dout", 32'(dout), 32'h00);
`endif

    // Data path works again after the flush
    we = 1'b1;
    din = 8'h77;
    tick();
    we = 1'b0;
    re = 1'b1;
    tick();
    re = 1'b0;
    check("post_dout", 32'(dout), 32'h77);
    check("post_valid", 32'(dout_valid), 32'd1);
    check("post_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
